// File: rtl/video_fb.sv
// Framebuffer video controller: PAL/NTSC 15 kHz timing, RGB332 frame buffer scan-out
// with integer pixel replication, CPU write port, scanline dimming and frame interrupt.
module video_fb #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 200,
  parameter int HSCALE   = 4,
  parameter int VSCALE   = 2,
  parameter int PAL_HFP  = 51,
  parameter int PAL_HSW  = 63,
  parameter int PAL_HBP  = 110,
  parameter int NTSC_HFP = 56,
  parameter int NTSC_HSW = 63,
  parameter int NTSC_HBP = 99,
  parameter int PAL_VFP  = 46,
  parameter int PAL_VSW  = 2,
  parameter int PAL_VBP  = 64,
  parameter int NTSC_VFP = 23,
  parameter int NTSC_VSW = 3,
  parameter int NTSC_VBP = 36,
  localparam int FB_W    = H_ACTIVE / HSCALE,
  localparam int FB_H    = V_ACTIVE / VSCALE,
  localparam int FB_SIZE = FB_W * FB_H,
  localparam int AW      = $clog2(FB_SIZE)
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic          pal,
  input  logic          scanlines,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_data,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [5:0]    r,
  output logic [5:0]    g,
  output logic [5:0]    b,
  output logic          vblank,
  output logic          frame_irq
);

  localparam int PAL_HTOT  = H_ACTIVE + PAL_HFP + PAL_HSW + PAL_HBP;
  localparam int NTSC_HTOT = H_ACTIVE + NTSC_HFP + NTSC_HSW + NTSC_HBP;
  localparam int PAL_VTOT  = V_ACTIVE + PAL_VFP + PAL_VSW + PAL_VBP;
  localparam int NTSC_VTOT = V_ACTIVE + NTSC_VFP + NTSC_VSW + NTSC_VBP;
  localparam int HTOT_MAX  = (PAL_HTOT > NTSC_HTOT) ? PAL_HTOT : NTSC_HTOT;
  localparam int VTOT_MAX  = (PAL_VTOT > NTSC_VTOT) ? PAL_VTOT : NTSC_VTOT;
  localparam int HW        = $clog2(HTOT_MAX);
  localparam int VW        = $clog2(VTOT_MAX);
  localparam int SHW       = (HSCALE > 1) ? $clog2(HSCALE) : 1;
  localparam int SVW       = (VSCALE > 1) ? $clog2(VSCALE) : 1;
  localparam logic [AW:0]  FB_SIZE_C = (AW+1)'(FB_SIZE);
  localparam logic [AW-1:0] FB_W_C   = AW'(FB_W);

  // Stage 0: timing counters and frame-buffer address
  logic            r_pal_q;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic [SHW-1:0]  r_hsub;
  logic [SVW-1:0]  r_vsub;
  logic [AW-1:0]   r_line_base;
  logic [AW-1:0]   r_rd_addr;

  logic [HW-1:0]   w_htot_m1, w_hs_start, w_hs_end;
  logic [VW-1:0]   w_vtot_m1, w_vs_start, w_vs_end;
  logic            w_h_last, w_v_last, w_h_vis, w_v_vis, w_vis;
  logic            w_hs_raw, w_vs_raw, w_irq_raw, w_dim_raw;
  logic [AW-1:0]   w_next_base;

  // Porch set follows the latched mode so a frame never changes geometry midway
  always_comb begin
    if (r_pal_q) begin
      w_htot_m1  = HW'(PAL_HTOT - 1);
      w_hs_start = HW'(H_ACTIVE + PAL_HFP);
      w_hs_end   = HW'(H_ACTIVE + PAL_HFP + PAL_HSW);
      w_vtot_m1  = VW'(PAL_VTOT - 1);
      w_vs_start = VW'(V_ACTIVE + PAL_VFP);
      w_vs_end   = VW'(V_ACTIVE + PAL_VFP + PAL_VSW);
    end else begin
      w_htot_m1  = HW'(NTSC_HTOT - 1);
      w_hs_start = HW'(H_ACTIVE + NTSC_HFP);
      w_hs_end   = HW'(H_ACTIVE + NTSC_HFP + NTSC_HSW);
      w_vtot_m1  = VW'(NTSC_VTOT - 1);
      w_vs_start = VW'(V_ACTIVE + NTSC_VFP);
      w_vs_end   = VW'(V_ACTIVE + NTSC_VFP + NTSC_VSW);
    end
  end

  assign w_h_last    = (r_h_cnt == w_htot_m1);
  assign w_v_last    = (r_v_cnt == w_vtot_m1);
  assign w_h_vis     = (r_h_cnt < HW'(H_ACTIVE));
  assign w_v_vis     = (r_v_cnt < VW'(V_ACTIVE));
  assign w_vis       = w_h_vis && w_v_vis;
  assign w_hs_raw    = !((r_h_cnt >= w_hs_start) && (r_h_cnt < w_hs_end));
  assign w_vs_raw    = !((r_v_cnt >= w_vs_start) && (r_v_cnt < w_vs_end));
  assign w_irq_raw   = (r_h_cnt == '0) && (r_v_cnt == VW'(V_ACTIVE));
  assign w_dim_raw   = scanlines && (VSCALE >= 2) && (r_vsub == SVW'(VSCALE - 1));
  assign w_next_base = r_line_base + FB_W_C;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_pal_q     <= 1'b1;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_hsub      <= '0;
      r_vsub      <= '0;
      r_line_base <= '0;
      r_rd_addr   <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_hsub  <= '0;
      if (w_v_last) begin
        r_v_cnt     <= '0;
        r_pal_q     <= pal;
        r_vsub      <= '0;
        r_line_base <= '0;
        r_rd_addr   <= '0;
      end else begin
        r_v_cnt <= r_v_cnt + 1'b1;
        // Replay the same frame-buffer row until VSCALE display lines are done
        if (w_v_vis) begin
          if (r_vsub == SVW'(VSCALE - 1)) begin
            r_vsub      <= '0;
            r_line_base <= w_next_base;
            r_rd_addr   <= w_next_base;
          end else begin
            r_vsub    <= r_vsub + 1'b1;
            r_rd_addr <= r_line_base;
          end
        end
      end
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
      if (w_vis) begin
        if (r_hsub == SHW'(HSCALE - 1)) begin
          r_hsub    <= '0;
          r_rd_addr <= r_rd_addr + 1'b1;
        end else begin
          r_hsub <= r_hsub + 1'b1;
        end
      end
    end
  end

  // Stage 1: VRAM read; write-then-read on one address returns the old byte
  logic [7:0] r_vram [FB_SIZE];
  logic [7:0] r_pix;

  always_ff @(posedge pclk) begin
    if (cpu_wr && ({1'b0, cpu_addr} < FB_SIZE_C)) begin
      r_vram[cpu_addr] <= cpu_data;
    end
    r_pix <= r_vram[r_rd_addr];
  end

  logic r_s1_hs, r_s1_vs, r_s1_de, r_s1_vb, r_s1_dim, r_s1_irq;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
      r_s1_de  <= 1'b0;
      r_s1_vb  <= 1'b0;
      r_s1_dim <= 1'b0;
      r_s1_irq <= 1'b0;
    end else begin
      r_s1_hs  <= w_hs_raw;
      r_s1_vs  <= w_vs_raw;
      r_s1_de  <= w_vis;
      r_s1_vb  <= !w_v_vis;
      r_s1_dim <= w_dim_raw;
      r_s1_irq <= w_irq_raw;
    end
  end

  // Stage 2: colour expansion and registered outputs
  logic [5:0] w_r6, w_g6, w_b6;
  logic [5:0] w_r_out, w_g_out, w_b_out;

  assign w_r6 = {r_pix[7:5], r_pix[7:5]};
  assign w_g6 = {r_pix[4:2], r_pix[4:2]};
  assign w_b6 = {r_pix[1:0], r_pix[1:0], r_pix[1:0]};

  assign w_r_out = !r_s1_de ? 6'd0 : (r_s1_dim ? (w_r6 >> 1) : w_r6);
  assign w_g_out = !r_s1_de ? 6'd0 : (r_s1_dim ? (w_g6 >> 1) : w_g6);
  assign w_b_out = !r_s1_de ? 6'd0 : (r_s1_dim ? (w_b6 >> 1) : w_b6);

  logic       r_hs, r_vs, r_de, r_vb, r_irq;
  logic [5:0] r_r, r_g, r_b;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_de  <= 1'b0;
      r_vb  <= 1'b0;
      r_irq <= 1'b0;
      r_r   <= '0;
      r_g   <= '0;
      r_b   <= '0;
    end else begin
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
      r_de  <= r_s1_de;
      r_vb  <= r_s1_vb;
      r_irq <= r_s1_irq;
      r_r   <= w_r_out;
      r_g   <= w_g_out;
      r_b   <= w_b_out;
    end
  end

  assign hs        = r_hs;
  assign vs        = r_vs;
  assign de        = r_de;
  assign vblank    = r_vb;
  assign frame_irq = r_irq;
  assign r         = r_r;
  assign g         = r_g;
  assign b         = r_b;

endmodule

// File: doc/video_fb.md
# video_fb

Parametrised framebuffer video controller. It generates PAL or NTSC 15 kHz timing from a single pixel clock and scans an internal RGB332 frame buffer with integer horizontal and vertical pixel replication. The frame buffer is written through a CPU write port in the same clock domain. The block sits between the SoC bus and the video DAC/scan-doubler. It adds the following over the fixed 160x100 controller:
- generic resolution and scaling,
- a working write port,
- an aligned data-enable output,
- optional scanline dimming,
- a frame interrupt,
- a glitch-free PAL/NTSC switch.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 200: visible lines per frame.
- HSCALE, 4: pclk cycles per frame-buffer pixel (≥1).
- VSCALE, 2: display lines per frame-buffer line (≥1).
- PAL_HFP/HSW/HBP, 51/63/110: PAL horizontal front porch, sync width, back porch (pclk).
- NTSC_HFP/HSW/HBP, 56/63/99: NTSC horizontal timing.
- PAL_VFP/VSW/VBP, 46/2/64: PAL vertical timing (lines).
- NTSC_VFP/VSW/VBP, 23/3/36: NTSC vertical timing.
- Derived, not overridable: FB_W=H_ACTIVE/HSCALE, FB_H=V_ACTIVE/VSCALE, FB_SIZE=FB_W*FB_H, AW=clog2(FB_SIZE).

Ports:
- pclk  in  1  pixel clock, sole clock. All logic rises on it.
- reset_n  in  1  asynchronous, active-low reset.
- pal  in  1  mode request: 1=PAL, 0=NTSC.
- scanlines  in  1  enables scanline dimming.
- cpu_wr  in  1  write strobe, one write per cycle.
- cpu_addr  in  AW  frame-buffer address.
- cpu_data  in  8  pixel data, RGB332.
- hs  out  1  horizontal sync, active low.
- vs  out  1  vertical sync, active low.
- de  out  1  data enable; high for visible pixels.
- r, g, b  out  6 each  colour.
- vblank  out  1  high while v_cnt ≥ V_ACTIVE (aligned with the other outputs).
- frame_irq  out  1  one-cycle pulse at the start of vblank.

## Operation
Mode latch:
- pal_q resets to 1. It loads pal only at frame wrap (h_cnt=HTOT-1 and v_cnt=VTOT-1).
- Porch values come from pal_q, so timing never changes mid-frame.
- HTOT=H_ACTIVE+HFP+HSW+HBP. VTOT=V_ACTIVE+VFP+VSW+VBP. With defaults: PAL 864x312, NTSC 858x262.

Counters:
- h_cnt counts 0..HTOT-1, then wraps.
- v_cnt increments when h_cnt wraps and wraps after VTOT-1.
- Visible region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Sync: hs_raw low for h_cnt in [H_ACTIVE+HFP, H_ACTIVE+HFP+HSW). vs_raw low for v_cnt in [V_ACTIVE+VFP, V_ACTIVE+VFP+VSW).

Address generation (no dividers):
- hsub counts 0..HSCALE-1 during visible pixels. rd_addr increments when hsub wraps.
- At the end of each visible line, rd_addr returns to line_base.
- vsub counts 0..VSCALE-1. On its wrap, line_base advances by FB_W.
- line_base, rd_addr, hsub and vsub all clear at v_cnt=VTOT-1 end of line.

VRAM:
- Inferred simple dual-port, FB_SIZE x 8, synchronous read.
- A write with cpu_addr ≥ FB_SIZE is ignored (no aliasing).
- When a read and a write hit the same address in the same cycle, the read returns the old data.
- Reset does not clear VRAM.

Colour:
- Bit-replicated expansion: r={p[7:5],p[7:5]}, g={p[4:2],p[4:2]}, b={p[1:0],p[1:0],p[1:0]}.
- Dimming applies when scanlines=1, VSCALE≥2 and vsub=VSCALE-1. Each 6-bit component is then shifted right by 1.
- Outside the visible region r/g/b=0.

frame_irq:
- Pulses when v_cnt changes from V_ACTIVE-1 to V_ACTIVE (h_cnt=0).

## Timing
Pipeline and latency:
- Stage 0: counters and address.
- Stage 1: VRAM read; hs/vs/de/vblank/dim delayed by one cycle.
- Stage 2: registered outputs.
- Every output lags its counter state by exactly 2 pclk, and all outputs stay mutually aligned.

Reset values:
- h_cnt=0, v_cnt=0, all address/sub counters=0, pal_q=1.
- hs=1, vs=1, de=0, r=g=b=0, vblank=0, frame_irq=0.
- Cycle 0 is the first pclk edge after reset_n rises; at cycle 0, h_cnt=0 and v_cnt=0.

Reset mid-frame:
- All outputs return to their reset values immediately (asynchronous).
- The frame restarts at line 0 after release.

CPU write:
- Data is visible to scan-out on any read issued in a later cycle.

## Test plan
- Reset/idle, PAL, defaults: hs first falls at cycle 693 and stays low for 63 cycles; period 864. vs is low for 2 lines starting at line 246. de is high for 640 cycles per line on lines 0-199.
- Write 0xE0 to addr 0, 0x1C to addr 1, 0x03 to addr 161, scanlines=0:
  - Line 0: pixels 0-3 give r=3F,g=0,b=0; pixels 4-7 give g=3F.
  - Line 1: identical to line 0.
  - Line 2: pixels 4-7 give b=3F.
- Same writes with scanlines=1: line 0 r=3F, line 1 r=1F; lines 2/3 repeat the pattern.
- Write to cpu_addr=16000 (FB_SIZE) with data 0xFF: no visible pixel changes; addr 0 keeps its prior value.
- Toggle pal 1→0 mid-frame: the current frame completes at 864x312. The next frame uses 858x262, with hs low at h_cnt 696..758 (outputs 2 cycles later).
- frame_irq: exactly one single-cycle pulse per frame, coincident with vblank rising, observed over 3 frames in each mode.
- Assert reset_n low mid-line: hs=1, vs=1, de=0, rgb=0 within the same cycle. After release, the line-0 timing matches the first scenario.
